// File: rtl/rv_ctrl_pkg.sv
// Shared constants and types for the RV32I-subset multi-cycle control unit:
// opcode map, FSM state codes, ALU operation codes and the control-word layout.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_IALU,
    CLS_MEM,
    CLS_BRANCH
  } op_class_e;

  // Everything the datapath sees, gathered so reset can blank it in one place.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       alu_src_b;
    logic [3:0] alu_ctrl;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    return op inside {OPC_R, OPC_IALU, OPC_LW, OPC_SW, OPC_BRANCH};
  endfunction

  function automatic op_class_e op_class(input logic [6:0] op);
    case (op)
      OPC_IALU:       return CLS_IALU;
      OPC_LW, OPC_SW: return CLS_MEM;
      OPC_BRANCH:     return CLS_BRANCH;
      default:        return CLS_R;
    endcase
  endfunction

endpackage

// File: rtl/alu_control.sv
// ALU operation decode from funct3, funct7[5] and the instruction class.
module alu_control
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  op_class_e  op_class_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    // NOTE: default first so no path through the cases leaves the output unassigned (no latch).
    alu_ctrl_o = ALU_ADD;
    case (op_class_i)
      CLS_MEM:    alu_ctrl_o = ALU_ADD;
      CLS_BRANCH: alu_ctrl_o = ALU_SUB;
      default: begin
        case (funct3_i)
          // Immediate forms have no SUBI; funct7[5] is immediate data there.
          3'b000:  alu_ctrl_o = (op_class_i == CLS_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = funct7_5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port,
// with a per-access wait timeout and a sticky trap state.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [2:0] state
);

  localparam bit         TIMEOUT_EN = (WAIT_MAX != 0);
  localparam logic [8:0] WAIT_LIM   = 9'(WAIT_MAX);

  state_e     state_q, state_d;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic [6:0] f7_q;
  logic [7:0] wait_q, wait_d;

  ctrl_t      ctl, ctl_o;
  op_class_e  cls;
  logic [3:0] alu_op;
  logic       is_lw, is_sw;
  logic       br_ok, br_taken;
  logic       wait_inc;
  logic       unused_f7;

  assign cls      = op_class(op_q);
  assign is_lw    = (op_q == OPC_LW);
  assign is_sw    = (op_q == OPC_SW);
  assign br_ok    = (f3_q == 3'b000) || (f3_q == 3'b001);
  assign br_taken = (f3_q == 3'b000) ? zero : !zero;

  // Only funct7[5] steers the ALU; the remaining latched bits are kept for debug.
  assign unused_f7 = ^{f7_q[6], f7_q[4:0]};

  alu_control u_alu_control (
    .funct3_i   (f3_q),
    .funct7_5_i (f7_q[5]),
    .op_class_i (cls),
    .alu_ctrl_o (alu_op)
  );

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: begin
        ctl.mem_req = 1'b1;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = ST_DECODE;
        end
      end
      ST_DECODE: state_d = is_legal_opcode(opcode) ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        ctl.alu_ctrl = alu_op;
        unique case (cls)
          CLS_R: state_d = ST_WB;
          CLS_IALU: begin
            ctl.alu_src_b = 1'b1;
            state_d       = ST_WB;
          end
          CLS_MEM: begin
            ctl.alu_src_b = 1'b1;
            state_d       = ST_MEM;
          end
          CLS_BRANCH: begin
            if (br_ok) begin
              ctl.pc_write = br_taken;
              ctl.pc_src   = br_taken;
              state_d      = ST_FETCH;
            end else begin
              state_d = ST_TRAP;
            end
          end
        endcase
      end
      ST_MEM: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        ctl.mem_we  = is_sw;
        if (mem_ready) state_d = is_sw ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = is_lw;
        state_d        = ST_FETCH;
      end
      ST_TRAP: ctl.illegal = 1'b1;
      default: state_d = ST_TRAP;
    endcase

    // A stalled cycle that would bring the count to the limit traps instead.
    wait_inc = ctl.mem_req && !mem_ready;
    if (TIMEOUT_EN && wait_inc && (({1'b0, wait_q} + 9'd1) == WAIT_LIM)) begin
      state_d = ST_TRAP;
    end

    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (wait_inc && wait_q != 8'hFF) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == ST_DECODE) begin
        op_q <= opcode;
        f3_q <= funct3;
        f7_q <= funct7;
      end
    end
  end

  // Reset blanks every output combinationally so an in-flight access is dropped at once.
  assign ctl_o      = reset ? '0 : ctl;
  assign mem_req    = ctl_o.mem_req;
  assign mem_we     = ctl_o.mem_we;
  assign iord       = ctl_o.iord;
  assign ir_write   = ctl_o.ir_write;
  assign pc_write   = ctl_o.pc_write;
  assign pc_src     = ctl_o.pc_src;
  assign alu_src_b  = ctl_o.alu_src_b;
  assign alu_ctrl   = ctl_o.alu_ctrl;
  assign reg_write  = ctl_o.reg_write;
  assign mem_to_reg = ctl_o.mem_to_reg;
  assign illegal    = ctl_o.illegal;
  assign state      = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: directed vector table, hand sequences for reset/trace,
// and randomized instructions compared against an instruction-level model.
module tb_multicycle_control;

  localparam int W = 4;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LW_OP = 7'b0000011;
  localparam logic [6:0] SW_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_b;
  logic [3:0] alu_ctrl;
  logic       reg_write, mem_to_reg, illegal;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_control #(.WAIT_MAX(W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state)
  );

  int checks = 0;
  int errors = 0;
  int trace_q[$];

  typedef struct {
    int timeout, trap, cycles, exec_seen, alu, alu_b, pcw_exec, pcsrc_exec;
    int rw_cnt, m2r, memwe, mem_iord, pcw_cnt, ill_cnt;
  } res_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         z;
    int         fw, mw;
    int         exp_cycles, exp_trap, exp_alu, exp_pcw, exp_rw;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Instruction-level expectations straight from the opcode/timing rules.
  function automatic res_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input bit z, input int fw, input int mw);
    res_t r;
    int   alu_tab[8];
    bit   is_r, is_i, is_lw, is_sw, is_br, taken;
    r = '{default: 0};
    alu_tab = '{0, 5, 8, 9, 4, 6, 3, 2};
    is_r = (op == R_OP); is_i = (op == I_OP); is_lw = (op == LW_OP);
    is_sw = (op == SW_OP); is_br = (op == BR_OP);
    if (fw >= W) begin r.trap = 1; r.cycles = W; return r; end
    r.pcw_cnt = 1;
    r.cycles  = fw + 2;
    if (!(is_r || is_i || is_lw || is_sw || is_br)) begin r.trap = 1; return r; end
    r.exec_seen = 1;
    r.cycles++;
    if (is_br) begin
      r.alu = 1;
      if (f3 > 3'd1) begin r.trap = 1; return r; end
      taken = (f3 == 3'd0) ? z : !z;
      r.pcw_exec = int'(taken); r.pcsrc_exec = int'(taken); r.pcw_cnt += int'(taken);
      return r;
    end
    if (is_lw || is_sw) begin
      r.alu_b = 1; r.mem_iord = 1; r.memwe = int'(is_sw);
      if (mw >= W) begin r.trap = 1; r.cycles += W; return r; end
      r.cycles += mw + 1;
      if (is_sw) return r;
      r.m2r = 1; r.rw_cnt = 1; r.cycles++;
      return r;
    end
    r.alu_b = int'(is_i);
    r.alu   = alu_tab[f3];
    if (f3 == 3'd5 && f7[5]) r.alu = 7;
    if (f3 == 3'd0 && is_r && f7[5]) r.alu = 1;
    r.rw_cnt = 1;
    r.cycles++;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct3 = '0; funct7 = '0; zero = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle until the DUT is back in FETCH or traps.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input bit z, input int fw, input int mw, input bit scramble,
                           output res_t o);
    int   phase, waited;
    bit   left_fetch, seen_decode, done;
    logic [2:0] st;
    o = '{default: 0};
    phase = 0; waited = 0; left_fetch = 0; seen_decode = 0; done = 0;
    trace_q.delete();
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (scramble && seen_decode) begin
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      end else begin
        opcode = op; funct3 = f3; funct7 = f7;
      end
      zero = z;
      if (mem_req) mem_ready = (waited >= ((phase == 0) ? fw : mw));
      else mem_ready = 1'($urandom_range(0, 1));
      #1;
      st = state;
      trace_q.push_back(int'(st));
      if (st != 3'd0) left_fetch = 1;
      if (st == 3'd1) seen_decode = 1;
      case (st)
        3'd2: begin
          o.exec_seen = 1; o.alu = int'(alu_ctrl); o.alu_b = int'(alu_src_b);
          o.pcw_exec = int'(pc_write); o.pcsrc_exec = int'(pc_src);
        end
        3'd3: begin
          o.memwe = o.memwe | int'(mem_we); o.mem_iord = o.mem_iord | int'(iord);
        end
        3'd4: o.m2r = int'(mem_to_reg);
        default: ;
      endcase
      o.rw_cnt += int'(reg_write); o.pcw_cnt += int'(pc_write); o.ill_cnt += int'(illegal);
      if (mem_req && mem_ready) begin phase++; waited = 0; end
      else if (mem_req) waited++;
      @(posedge clk);
      #1;
      o.cycles = cyc + 1;
      if (state == 3'd5) begin o.trap = 1; done = 1; end
      else if (state == 3'd0 && left_fetch) done = 1;
    end
    if (!done) o.timeout = 1;
    trace_q.push_back(int'(state));
  endtask

  task automatic trap_hold(input string tag);
    repeat (2) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check({tag, ".trap_state"}, state, 5);
      check({tag, ".trap_illegal"}, illegal, 1);
    end
    do_reset();
  endtask

  task automatic compare(input string tag, input res_t a, input res_t e);
    check({tag, ".timeout"}, a.timeout, 0);
    check({tag, ".trap"}, a.trap, e.trap);
    check({tag, ".cycles"}, a.cycles, e.cycles);
    check({tag, ".exec_seen"}, a.exec_seen, e.exec_seen);
    check({tag, ".alu_ctrl"}, a.alu, e.alu);
    check({tag, ".alu_src_b"}, a.alu_b, e.alu_b);
    check({tag, ".pc_write_exec"}, a.pcw_exec, e.pcw_exec);
    check({tag, ".pc_src_exec"}, a.pcsrc_exec, e.pcsrc_exec);
    check({tag, ".reg_write_cnt"}, a.rw_cnt, e.rw_cnt);
    check({tag, ".mem_to_reg"}, a.m2r, e.m2r);
    check({tag, ".mem_we"}, a.memwe, e.memwe);
    check({tag, ".iord_mem"}, a.mem_iord, e.mem_iord);
    check({tag, ".pc_write_cnt"}, a.pcw_cnt, e.pcw_cnt);
    check({tag, ".illegal_early"}, a.ill_cnt, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[$];
    res_t       o, e;
    int         found;
    logic [6:0] rop;
    int         rfw, rmw;

    // Reset state: every output forced low while reset is high.
    #12;
    check("reset.outputs", {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_b,
                            alu_ctrl, reg_write, mem_to_reg, illegal}, 0);
    check("reset.state", state, 0);
    do_reset();

    //          op     f3      f7         z  fw mw cyc trap alu pcw rw
    vecs.push_back('{R_OP,  3'd0, 7'h00, 0, 0, 0, 4, 0, 0, 0, 1});  // add
    vecs.push_back('{LW_OP, 3'd2, 7'h00, 0, 0, 2, 7, 0, 0, 0, 1});  // lw, 2 MEM waits
    vecs.push_back('{SW_OP, 3'd2, 7'h00, 0, 1, 0, 5, 0, 0, 0, 0});  // sw, 1 fetch wait
    vecs.push_back('{BR_OP, 3'd0, 7'h00, 1, 0, 0, 3, 0, 1, 1, 0});  // beq taken
    vecs.push_back('{BR_OP, 3'd0, 7'h00, 0, 0, 0, 3, 0, 1, 0, 0});  // beq not taken
    vecs.push_back('{BR_OP, 3'd1, 7'h00, 1, 0, 0, 3, 0, 1, 0, 0});  // bne not taken
    vecs.push_back('{BR_OP, 3'd1, 7'h00, 0, 0, 0, 3, 0, 1, 1, 0});  // bne taken
    vecs.push_back('{I_OP,  3'd5, 7'h20, 0, 0, 0, 4, 0, 7, 0, 1});  // srai
    vecs.push_back('{I_OP,  3'd5, 7'h00, 0, 0, 0, 4, 0, 6, 0, 1});  // srli
    vecs.push_back('{I_OP,  3'd0, 7'h20, 0, 0, 0, 4, 0, 0, 0, 1});  // addi, imm bit set
    vecs.push_back('{I_OP,  3'd3, 7'h00, 0, 0, 0, 4, 0, 9, 0, 1});  // sltiu
    vecs.push_back('{R_OP,  3'd0, 7'h20, 0, 0, 0, 4, 0, 1, 0, 1});  // sub
    vecs.push_back('{R_OP,  3'd5, 7'h20, 0, 0, 0, 4, 0, 7, 0, 1});  // sra
    vecs.push_back('{R_OP,  3'd7, 7'h00, 0, 0, 0, 4, 0, 2, 0, 1});  // and
    vecs.push_back('{R_OP,  3'd2, 7'h00, 0, 0, 0, 4, 0, 8, 0, 1});  // slt
    vecs.push_back('{I_OP,  3'd6, 7'h00, 0, 0, 0, 4, 0, 3, 0, 1});  // ori
    vecs.push_back('{R_OP,  3'd1, 7'h00, 0, 0, 0, 4, 0, 5, 0, 1});  // sll
    vecs.push_back('{R_OP,  3'd4, 7'h00, 0, 0, 0, 4, 0, 4, 0, 1});  // xor
    vecs.push_back('{7'h7F, 3'd0, 7'h00, 0, 0, 0, 2, 1, 0, 0, 0});  // illegal opcode
    vecs.push_back('{R_OP,  3'd0, 7'h00, 0, 4, 0, 4, 1, 0, 0, 0});  // fetch timeout
    vecs.push_back('{LW_OP, 3'd2, 7'h00, 0, 0, 4, 7, 1, 0, 0, 0});  // MEM timeout
    vecs.push_back('{BR_OP, 3'd4, 7'h00, 0, 0, 0, 3, 1, 1, 0, 0});  // unsupported branch

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].fw, vecs[i].mw, 1'b0, o);
      check($sformatf("vec%0d.cycles", i), o.cycles, vecs[i].exp_cycles);
      check($sformatf("vec%0d.trap", i), o.trap, vecs[i].exp_trap);
      check($sformatf("vec%0d.alu_ctrl", i), o.alu, vecs[i].exp_alu);
      check($sformatf("vec%0d.pc_write_exec", i), o.pcw_exec, vecs[i].exp_pcw);
      check($sformatf("vec%0d.reg_write", i), o.rw_cnt, vecs[i].exp_rw);
      if (o.trap != 0 || o.timeout != 0) trap_hold($sformatf("vec%0d", i));
    end

    // add with zero-wait memory walks FETCH, DECODE, EXEC, WB, FETCH.
    run_instr(R_OP, 3'd0, 7'h00, 1'b0, 0, 0, 1'b0, o);
    check("add_trace.len", trace_q.size(), 5);
    if (trace_q.size() == 5) begin
      check("add_trace.s0", trace_q[0], 0);
      check("add_trace.s1", trace_q[1], 1);
      check("add_trace.s2", trace_q[2], 2);
      check("add_trace.s3", trace_q[3], 4);
      check("add_trace.s4", trace_q[4], 0);
    end

    // Reset in the middle of a stalled sw: outputs drop, no write after release.
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      opcode = SW_OP; funct3 = 3'd2; funct7 = '0; zero = 1'b0;
      mem_ready = (state != 3'd3);
      #1;
      if (state == 3'd3) found = 1;
    end
    check("sw_reset.reached_mem", found, 1);
    check("sw_reset.mem_we_before", mem_we, 1);
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    check("sw_reset.outputs_hi", {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_b,
                                  alu_ctrl, reg_write, mem_to_reg, illegal, state}, 0);
    @(negedge clk);
    #1;
    check("sw_reset.outputs_hold", {mem_req, mem_we, illegal, state}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check($sformatf("sw_reset.state%0d", c), state, 0);
      check($sformatf("sw_reset.no_write%0d", c), mem_we, 0);
      check($sformatf("sw_reset.fetch_req%0d", c), {mem_req, iord}, 2'b10);
    end
    do_reset();

    // Randomized instructions; op fields are scrambled once DECODE has passed.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 5))
        0: rop = R_OP;
        1: rop = I_OP;
        2: rop = LW_OP;
        3: rop = SW_OP;
        4: rop = BR_OP;
        default: rop = 7'($urandom);
      endcase
      rfw = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      rmw = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      funct3 = 3'($urandom);
      funct7 = $urandom_range(0, 1) ? 7'h20 : 7'($urandom);
      e = model(rop, funct3, funct7, 1'($urandom), rfw, rmw);
      zero = 1'b0;
      begin
        logic [2:0] f3v;
        logic [6:0] f7v;
        bit         zv;
        f3v = 3'($urandom);
        f7v = $urandom_range(0, 1) ? 7'h20 : 7'($urandom);
        zv  = 1'($urandom);
        e = model(rop, f3v, f7v, zv, rfw, rmw);
        run_instr(rop, f3v, f7v, zv, rfw, rmw, 1'b1, o);
      end
      compare($sformatf("rand%0d", n), o, e);
      if (o.trap != 0 || o.timeout != 0) trap_hold($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
